// File: rtl/cpu_pkg.sv
// Shared CPU types and constants: fetch FSM states, opcode values and datapath widths.
package cpu_pkg;
    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 16;
    localparam int OPC_W   = 5;

    localparam logic [OPC_W-1:0] OPC_B    = 5'b11000;
    localparam logic [OPC_W-1:0] OPC_BEQ  = 5'b11001;
    localparam logic [OPC_W-1:0] OPC_JMP  = 5'b11010;
    localparam logic [OPC_W-1:0] OPC_HALT = 5'b11111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    function automatic logic [OPC_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[INSTR_W-1 -: OPC_W];
    endfunction
endpackage

// File: rtl/fetch_buf.sv
// Fetch output register backed by a one-entry skid slot, with load/consume/flush controls.
module fetch_buf
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               load,
    input  logic               consume,
    input  logic [INSTR_W-1:0] load_instr,
    input  logic [ADDR_W-1:0]  load_pc,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  pc,
    output logic               skid_next,
    output logic               enter,
    output logic [INSTR_W-1:0] enter_instr
);
    logic               skid_full;
    logic [INSTR_W-1:0] skid_instr;
    logic [ADDR_W-1:0]  skid_pc;
    logic               from_skid;
    logic               from_load;
    logic               to_skid;
    logic [ADDR_W-1:0]  enter_pc;

    // A skid word always leaves before a newly loaded word so program order holds.
    always_comb begin
        from_skid   = consume && skid_full;
        from_load   = load && (!valid || consume) && !from_skid;
        to_skid     = load && !from_load;
        enter       = from_skid || from_load;
        enter_instr = from_skid ? skid_instr : load_instr;
        enter_pc    = from_skid ? skid_pc : load_pc;
        skid_next   = !flush && ((skid_full && !consume) || to_skid);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid     <= 1'b0;
            instr     <= '0;
            pc        <= '0;
            skid_full <= 1'b0;
        end else if (flush) begin
            valid     <= 1'b0;
            skid_full <= 1'b0;
        end else begin
            skid_full <= skid_next;
            if (enter) begin
                valid <= 1'b1;
                instr <= enter_instr;
                pc    <= enter_pc;
            end else if (consume) begin
                valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (to_skid) begin
            skid_instr <= load_instr;
            skid_pc    <= load_pc;
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding memory request, redirect with late-ack drop, HALT detection.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        if_valid,
    output logic [15:0] if_instr,
    output logic [4:0]  if_opcode,
    output logic [15:0] if_pc,
    output logic        halted
);
    fetch_state_t       state;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  req_addr;
    logic               req;
    logic               drop;

    logic               consume;
    logic               req_done;
    logic               ack_ok;
    logic [ADDR_W-1:0]  pc_nxt;
    logic               skid_next;
    logic               buf_enter;
    logic [INSTR_W-1:0] enter_instr;
    logic               halt_now;
    logic               start;

    assign consume  = if_valid && !stall;
    assign req_done = req && imem_ack;
    assign ack_ok   = req_done && !drop && !redirect;
    assign pc_nxt   = ack_ok ? req_addr + 16'd1 : pc;
    assign halt_now = buf_enter && (opcode_of(enter_instr) == OPC_HALT);
    // A new request only starts if the returning word is guaranteed a slot.
    assign start    = (state == FETCH) && (!req || req_done) && !skid_next && !halt_now;

    fetch_buf u_buf (
        .clk         (clk),
        .rst         (rst),
        .flush       (redirect),
        .load        (ack_ok),
        .consume     (consume),
        .load_instr  (imem_rdata),
        .load_pc     (req_addr),
        .valid       (if_valid),
        .instr       (if_instr),
        .pc          (if_pc),
        .skid_next   (skid_next),
        .enter       (buf_enter),
        .enter_instr (enter_instr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
            req      <= 1'b0;
            drop     <= 1'b0;
        end else if (redirect) begin
            state <= FETCH;
            pc    <= redirect_pc;
            // An in-flight request must still complete; its data is thrown away.
            if (req && !imem_ack) begin
                drop <= 1'b1;
            end else begin
                drop     <= 1'b0;
                req      <= 1'b1;
                req_addr <= redirect_pc;
            end
        end else begin
            pc <= pc_nxt;
            if (req_done) begin
                drop <= 1'b0;
            end
            case (state)
                IDLE: begin
                    state    <= FETCH;
                    req      <= 1'b1;
                    req_addr <= pc;
                end
                FETCH: begin
                    if (halt_now) begin
                        state <= HALT;
                    end
                    if (start) begin
                        req      <= 1'b1;
                        req_addr <= pc_nxt;
                    end else if (req_done) begin
                        req <= 1'b0;
                    end
                end
                HALT: begin
                    if (req_done) begin
                        req <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign imem_req  = req;
    assign imem_addr = req_addr;
    assign halted    = (state == HALT);
    assign if_opcode = opcode_of(if_instr);
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random stall/redirect/latency against a program-order model.
module tb_fetch_stage;
    localparam logic [15:0] RST_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [4:0]  if_opcode;
    logic [15:0] if_pc;
    logic        halted;

    logic [15:0] mem [0:65535];
    int          lat = 0;
    int          wcnt;
    int          n_total = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    int          n_cons = 0;
    logic [15:0] exp_pc;
    logic        m_halted;
    logic        prev_hold;
    logic [15:0] prev_addr;

    fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_opcode   (if_opcode),
        .if_pc       (if_pc),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    // Memory responder: acks a request 'lat' cycles after it is first seen.
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = '0;
        wcnt       = 0;
        forever begin
            @(negedge clk);
            if (imem_req === 1'b1) begin
                if (wcnt >= lat) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem[imem_addr];
                    wcnt       = 0;
                end else begin
                    imem_ack   = 1'b0;
                    imem_rdata = 16'($urandom);
                    wcnt++;
                end
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = 16'($urandom);
                wcnt       = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One cycle: drive inputs, score decode consumption against program order, advance.
    task automatic step(input logic s, input logic r, input logic [15:0] t);
        logic [15:0] ew;
        stall       = s;
        redirect    = r;
        redirect_pc = t;
        if (prev_hold) begin
            chk("req_hold", imem_req, 1);
            chk("addr_hold", imem_addr, prev_addr);
        end
        if (rst === 1'b0 && !r && if_valid === 1'b1 && !s) begin
            ew = mem[exp_pc];
            chk("cons_pc", if_pc, exp_pc);
            chk("cons_instr", if_instr, ew);
            chk("cons_opcode", if_opcode, ew[15:11]);
            chk("cons_while_halted", m_halted, 0);
            if (ew[15:11] == 5'b11111) begin
                chk("halted_flag", halted, 1);
                m_halted = 1'b1;
            end
            exp_pc = exp_pc + 16'd1;
            n_cons++;
        end
        if (rst === 1'b1) begin
            exp_pc   = RST_PC;
            m_halted = 1'b0;
        end else if (r) begin
            exp_pc   = t;
            m_halted = 1'b0;
        end
        prev_hold = (rst === 1'b0) && (imem_req === 1'b1) && (imem_ack === 1'b0);
        prev_addr = imem_addr;
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] w;
        logic        found;
        logic        rs;
        logic        rr;

        for (int i = 0; i < 65536; i++) begin
            w = 16'($urandom);
            if (w[15:11] == 5'b11111) w[15] = 1'b0;
            mem[i] = w;
        end
        mem[8] = 16'hF800 | 16'($urandom_range(0, 2047));

        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        exp_pc = RST_PC; m_halted = 1'b0; prev_hold = 1'b0; prev_addr = '0;

        // Reset values, then first request two cycles after reset and 1 instr/cycle.
        step(0, 0, 16'h0);
        chk("rst_req", imem_req, 0);
        chk("rst_valid", if_valid, 0);
        chk("rst_instr", if_instr, 0);
        chk("rst_pc", if_pc, 0);
        chk("rst_halted", halted, 0);
        rst = 1'b0;
        step(0, 0, 16'h0);
        chk("first_req", imem_req, 1);
        chk("first_addr", imem_addr, 16'h0000);
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 16'h0);
            chk("stream_valid", if_valid, 1);
            chk("stream_pc", if_pc, k);
        end

        // Stall with 5 buffered: 6 lands in the skid, no request, then 5,6,7 in order.
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (if_valid === 1'b1 && if_pc === 16'd5) found = 1'b1;
            else step(0, 0, 16'h0);
        end
        chk("wait_pc5", found, 1);
        step(1, 0, 16'h0);
        chk("stall_req_low", imem_req, 0);
        chk("stall_pc5", if_pc, 5);
        step(1, 0, 16'h0);
        step(1, 0, 16'h0);
        chk("release_pc5", if_pc, 5);
        step(0, 0, 16'h0);
        chk("release_pc6", if_pc, 6);
        step(0, 0, 16'h0);
        chk("release_pc7", if_pc, 7);

        // Latency 3: redirect during a pending request drops its data.
        lat = 3;
        step(0, 1, 16'h0010);
        found = 1'b0;
        for (int k = 0; k < 12 && !found; k++) begin
            if (imem_req === 1'b1 && imem_addr === 16'h0010) found = 1'b1;
            else step(0, 0, 16'h0);
        end
        chk("wait_req10", found, 1);
        step(0, 0, 16'h0);
        step(0, 1, 16'h0040);
        chk("drop_req", imem_req, 1);
        chk("drop_addr_a", imem_addr, 16'h0010);
        chk("drop_valid", if_valid, 0);
        step(0, 0, 16'h0);
        chk("drop_addr_b", imem_addr, 16'h0010);
        step(0, 0, 16'h0);
        chk("redir_req", imem_req, 1);
        chk("redir_addr", imem_addr, 16'h0040);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (if_valid === 1'b1) found = 1'b1;
            else step(0, 0, 16'h0);
        end
        chk("wait_valid40", found, 1);
        chk("first_pc40", if_pc, 16'h0040);

        // HALT word at 0x0008 stops fetching; redirect resumes.
        lat = 1;
        step(0, 1, 16'h0004);
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (halted === 1'b1) found = 1'b1;
            else step(0, 0, 16'h0);
        end
        chk("wait_halt", found, 1);
        chk("halt_req", imem_req, 0);
        chk("halt_pc", if_pc, 16'h0008);
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 16'h0);
            chk("halt_idle_req", imem_req, 0);
            chk("halt_stays", halted, 1);
        end
        chk("halt_drained", if_valid, 0);
        step(0, 1, 16'h0002);
        chk("resume_halted", halted, 0);
        chk("resume_req", imem_req, 1);
        chk("resume_addr", imem_addr, 16'h0002);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (if_valid === 1'b1) found = 1'b1;
            else step(0, 0, 16'h0);
        end
        chk("wait_resume", found, 1);
        chk("resume_pc", if_pc, 16'h0002);

        // Address wrap from 0xFFFF to 0x0000.
        lat = 0;
        step(0, 1, 16'hFFFE);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (imem_req === 1'b1 && imem_addr === 16'hFFFF) found = 1'b1;
            else step(0, 0, 16'h0);
        end
        chk("wait_ffff", found, 1);
        step(0, 0, 16'h0);
        chk("wrap_req", imem_req, 1);
        chk("wrap_addr", imem_addr, 16'h0000);

        // Reset while buffer and skid are both full.
        step(0, 1, 16'h0100);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (if_valid === 1'b1) found = 1'b1;
            else step(0, 0, 16'h0);
        end
        chk("wait_100", found, 1);
        step(1, 0, 16'h0);
        chk("full_req_low", imem_req, 0);
        chk("full_valid", if_valid, 1);
        rst = 1'b1;
        step(1, 0, 16'h0);
        chk("rst2_req", imem_req, 0);
        chk("rst2_valid", if_valid, 0);
        chk("rst2_instr", if_instr, 0);
        chk("rst2_opcode", if_opcode, 0);
        chk("rst2_pc", if_pc, 0);
        chk("rst2_halted", halted, 0);
        rst = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (if_valid === 1'b1) found = 1'b1;
            else step(0, 0, 16'h0);
        end
        chk("wait_after_rst", found, 1);
        chk("after_rst_pc", if_pc, RST_PC);

        // Random stall, redirect and latency against the program-order model.
        for (int c = 0; c < 2000; c++) begin
            if (c % 50 == 0) lat = $urandom_range(0, 3);
            rst = (c == 1000);
            rs  = ($urandom_range(0, 3) == 0);
            rr  = ($urandom_range(0, 29) == 0);
            step(rs, rr, 16'($urandom_range(0, 63)));
        end
        rst = 1'b0;
        step(0, 0, 16'h0);
        chk("stream_progress", (n_cons > 200), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
